pin_loopback_checker: RTL
=========================

// Module: pin_loopback_checker
// PURPOSE
//   Downstream checker for the D[109:0] board pin-walk pattern. Takes the pattern as
//   driven (expected) and the same pins read back through a loopback/probe header.
//   Resynchronises the readback, waits a settle time after each pattern step, then
//   compares. Keeps sticky per-pin fail map, error count, first failing pin, pass flag.
// PARAMETERS
//   WIDTH      110  pins under test
//   SETTLE     4    cycles from step to compare; must be >= 2 (synchroniser depth)
//   ERRW       16   err_count width, saturating
//   IDXW       7    first_fail width; 2**IDXW >= WIDTH
//   PASS_STEPS 256  consecutive clean compares needed to assert pass
// PORTS
//   pclk        in   1      system clock; sole clock
//   rst         in   1      asynchronous, active-high reset
//   step        in   1      1-cycle pulse: pattern generator just advanced
//   expected    in   WIDTH  pattern currently driven (pclk domain)
//   pins_in     in   WIDTH  raw readback pins, asynchronous
//   clear       in   1      synchronous clear of all statistics
//   busy        out  1      settle/compare in progress
//   fail_map    out  WIDTH  sticky OR of per-pin mismatches
//   err_count   out  ERRW   number of compares with any mismatch
//   first_fail  out  IDXW   lowest mismatching pin index of first failing compare
//   first_valid out  1      first_fail holds a valid index
//   pass        out  1      PASS_STEPS consecutive clean compares seen
//   overrun     out  1      sticky: step arrived while busy
// BEHAVIOUR
//   - Reset (async assert): state IDLE; all outputs, synchroniser flops, exp_q,
//     settle counter and good-run counter = 0. Release on a pclk edge only.
//   - pins_in -> 2-flop synchroniser (pins_sync); no other use of raw pins.
//   - FSM IDLE/SETTLE/COMPARE; busy = (state != IDLE).
//     IDLE: step=1 -> exp_q <= expected, cnt <= SETTLE-1, go SETTLE.
//     SETTLE: cnt decrements each edge; at cnt==0 go COMPARE.
//     COMPARE (exactly one cycle): diff = exp_q ^ pins_sync; update stats; go IDLE.
//   - Timing: step sampled at edge k -> busy high after edge k; compare cycle
//     sees pins_sync at edge k+SETTLE; results and busy=0 visible after k+SETTLE+1.
//   - Stats on COMPARE: fail_map |= diff. diff!=0: err_count +1, saturating at
//     all-ones; good_run <= 0; if !first_valid: first_fail <= lowest set bit of
//     diff, first_valid <= 1 (first_fail then frozen until clear/reset).
//     diff==0: good_run +1, saturating at PASS_STEPS. pass = (good_run==PASS_STEPS),
//     registered; drops on next failing compare.
//   - step while busy (including COMPARE cycle): ignored, overrun <= 1; compare in
//     flight unaffected.
//   - clear=1: any state -> IDLE next edge; fail_map, err_count, first_fail,
//     first_valid, good_run, pass, overrun <= 0. clear wins over simultaneous step
//     (that step is dropped, not flagged overrun).
//   - Reset mid-SETTLE/COMPARE aborts the compare; no stat update occurs.
//   - expected may change at any time; only value captured at step is used.
// TESTING
//   1 rst pulse mid-SETTLE with stats nonzero -> all outputs 0 immediately, busy=0.
//   2 pins_in=expected, single-hot walking pattern, 300 steps spaced 8 cycles ->
//     err_count=0, fail_map=0, pass=1 after 256th compare, overrun=0.
//   3 pin 37 stuck 0, expected bit37=1 on one step -> err_count=1, fail_map[37]=1,
//     first_fail=37, first_valid=1, pass=0; later fail on pin 3 keeps first_fail=37.
//   4 pins 90 and 5 mismatch in same compare -> first_fail=5, err_count +1,
//     fail_map bits 5,90 set.
//   5 second step 2 cycles after first (SETTLE=4) -> overrun=1, only one compare;
//     busy drops exactly SETTLE+1 edges after first step.
//   6 ERRW=4, 20 failing steps -> err_count=15; then clear+step same cycle ->
//     all stats 0, busy=0, overrun=0.

Source files
------------

// File: rtl/pin_loopback_checker.sv
// Checker for the board pin-walk pattern: resynchronises the loopback readback,
// waits a settle time after each step, then compares and keeps sticky statistics.

module pin_loopback_lane (
    input  logic pclk,
    input  logic rst,
    input  logic pin_raw,
    output logic pin_sync
);
    logic meta;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            meta     <= 1'b0;
            pin_sync <= 1'b0;
        end else begin
            meta     <= pin_raw;
            pin_sync <= meta;
        end
    end
endmodule

module pin_loopback_checker #(
    parameter int WIDTH      = 110,
    parameter int SETTLE     = 4,
    parameter int ERRW       = 16,
    parameter int IDXW       = 7,
    parameter int PASS_STEPS = 256
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             step,
    input  logic [WIDTH-1:0] expected,
    input  logic [WIDTH-1:0] pins_in,
    input  logic             clear,
    output logic             busy,
    output logic [WIDTH-1:0] fail_map,
    output logic [ERRW-1:0]  err_count,
    output logic [IDXW-1:0]  first_fail,
    output logic             first_valid,
    output logic             pass,
    output logic             overrun
);
    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int GRW  = $clog2(PASS_STEPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COMPARE} state_t;

    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] pins_sync;
    logic [GRW-1:0]   good_run;

    logic [WIDTH-1:0] diff;
    logic             any_fail;
    logic [IDXW-1:0]  lo_idx;
    logic [GRW-1:0]   good_inc;

    // Raw pins are only ever seen through the per-pin synchronisers.
    for (genvar gv = 0; gv < WIDTH; gv++) begin : g_lane
        pin_loopback_lane u_lane (
            .pclk     (pclk),
            .rst      (rst),
            .pin_raw  (pins_in[gv]),
            .pin_sync (pins_sync[gv])
        );
    end

    always_comb begin
        diff     = exp_q ^ pins_sync;
        any_fail = |diff;
        lo_idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (diff[i]) lo_idx = IDXW'(i);
        end
        good_inc = (good_run == GRW'(PASS_STEPS)) ? good_run : good_run + 1'b1;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            exp_q       <= '0;
            good_run    <= '0;
            fail_map    <= '0;
            err_count   <= '0;
            first_fail  <= '0;
            first_valid <= 1'b0;
            pass        <= 1'b0;
            overrun     <= 1'b0;
        end else if (clear) begin
            // A step coinciding with clear is dropped without flagging overrun.
            state       <= S_IDLE;
            cnt         <= '0;
            good_run    <= '0;
            fail_map    <= '0;
            err_count   <= '0;
            first_fail  <= '0;
            first_valid <= 1'b0;
            pass        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (step && state != S_IDLE) overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (step) begin
                        exp_q <= expected;
                        cnt   <= CNTW'(SETTLE - 1);
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) state <= S_COMPARE;
                    else           cnt   <= cnt - 1'b1;
                end
                S_COMPARE: begin
                    fail_map <= fail_map | diff;
                    if (any_fail) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        good_run <= '0;
                        pass     <= 1'b0;
                        if (!first_valid) begin
                            first_fail  <= lo_idx;
                            first_valid <= 1'b1;
                        end
                    end else begin
                        good_run <= good_inc;
                        pass     <= (good_inc == GRW'(PASS_STEPS));
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
